// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Memory, decode and control bundle for the instruction fetch
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    logic              idle;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc, idle,
        input  mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc, stall
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, idle,
        output mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc, stall
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with single outstanding read and an
//               in-order instruction FIFO; redirect flushes and restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 64,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fetch_unit_if.master bus
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_req_pc;
    logic [DATA_W-1:0]   r_fifo_data [DEPTH];
    logic [ADDR_W-1:0]   r_fifo_pc   [DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_req;
    logic w_issue;
    logic w_valid;
    logic w_pop;
    logic w_push;

    // The slot check at issue time guarantees room for the response.
    assign w_req   = !rst && (r_state == S_REQ) && (r_count < c_DEPTH) && !bus.stall;
    assign w_issue = w_req && bus.mem_gnt;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.inst_ready;
    assign w_push  = (r_state == S_WAIT) && bus.mem_rvalid && !bus.redirect;

    assign bus.mem_req    = w_req;
    assign bus.mem_addr   = r_fetch_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.inst_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : '0;
    assign bus.idle       = (r_state == S_REQ) && (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // An outstanding read must still be retired, but its data is stale.
            case (r_state)
                S_REQ:   r_state <= w_issue ? S_DROP : S_REQ;
                default: r_state <= bus.mem_rvalid ? S_REQ : S_DROP;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_issue) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (bus.mem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.mem_rdata;
                r_fifo_pc[r_wr_ptr]   <= r_req_pc;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized bench for fetch_unit against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    localparam int         ADDR_W   = 8;
    localparam int         DATA_W   = 64;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'h00;
    localparam int         PHASE_LEN = 500;

    logic clk;
    logic rst;

    fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    logic [63:0] mem [256];

    // Reference model: contents of the instruction buffer and the one read in flight.
    logic [7:0]  q_pc   [$];
    logic [63:0] q_data [$];
    logic [7:0]  m_pc;
    bit          m_out;
    bit          m_keep;
    logic [7:0]  m_out_pc;

    // Memory responder state.
    bit         pend_v;
    logic [7:0] pend_addr;
    int         pend_cnt;

    initial begin
        int  phase;
        int  rst_left;
        bit  prev_rst;
        bit  exp_req, exp_valid, m_issue, dut_issue, rv, resp, pop, deliver;

        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h0000_0001_0100_0010;   // LDRI r0
        mem[1] = 64'h0000_0001_0110_0020;   // LDRI r1
        mem[2] = 64'h0000_0002_0201_0000;   // ADD r2,r0,r1
        mem[3] = 64'h0000_0003_0200_0030;   // STRI r2

        rst             = 1'b1;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.stall       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check_val("rst_mem_req",    bus.mem_req,    0);
        check_val("rst_mem_addr",   bus.mem_addr,   RESET_PC);
        check_val("rst_inst_valid", bus.inst_valid, 0);
        check_val("rst_inst_data",  bus.inst_data,  0);
        check_val("rst_inst_pc",    bus.inst_pc,    0);
        check_val("rst_idle",       bus.idle,       1);

        m_pc     = RESET_PC;
        m_out    = 0;
        m_keep   = 0;
        m_out_pc = '0;
        pend_v   = 0;
        pend_addr = '0;
        pend_cnt = 0;
        rst_left = 0;
        prev_rst = 1;

        for (int cyc = 0; cyc < 5 * PHASE_LEN; cyc++) begin
            phase = cyc / PHASE_LEN;

            if (phase == 4 && rst_left == 0 && $urandom_range(0, 49) == 0)
                rst_left = $urandom_range(1, 3);
            rst = (rst_left > 0);
            if (rst_left > 0) rst_left--;

            case (phase)
                0: begin
                    bus.stall      = 1'b0;
                    bus.inst_ready = 1'b1;
                    bus.redirect   = 1'b0;
                end
                1: begin
                    bus.stall      = 1'b0;
                    bus.inst_ready = ($urandom_range(0, 5) == 0);
                    bus.redirect   = 1'b0;
                end
                2: begin
                    bus.stall      = ($urandom_range(0, 7) == 0);
                    bus.inst_ready = ($urandom_range(0, 3) != 0);
                    bus.redirect   = ($urandom_range(0, 29) == 0);
                end
                3: begin
                    bus.stall      = ($urandom_range(0, 2) != 0);
                    bus.inst_ready = $urandom_range(0, 1);
                    bus.redirect   = ($urandom_range(0, 14) == 0);
                end
                default: begin
                    bus.stall      = ($urandom_range(0, 3) == 0);
                    bus.inst_ready = $urandom_range(0, 1);
                    bus.redirect   = ($urandom_range(0, 9) == 0);
                end
            endcase
            case ($urandom_range(0, 3))
                0:       bus.redirect_pc = 8'h80;
                1:       bus.redirect_pc = 8'hfe;
                default: bus.redirect_pc = 8'($urandom);
            endcase

            deliver = pend_v && (pend_cnt == 0) && !rst;
            if (deliver) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem[pend_addr];
            end else if (!pend_v && !rst && phase >= 2 && $urandom_range(0, 9) == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = {$urandom, $urandom};
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = {$urandom, $urandom};
            end
            bus.mem_gnt = (phase == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);

            #1;
            exp_req   = !rst && !m_out && (q_pc.size() < DEPTH) && !bus.stall;
            exp_valid = (q_pc.size() != 0);
            check_val("mem_req",    bus.mem_req,    exp_req);
            check_val("mem_addr",   bus.mem_addr,   m_pc);
            check_val("inst_valid", bus.inst_valid, exp_valid);
            check_val("idle",       bus.idle,       !m_out && !exp_valid);
            if (exp_valid) begin
                check_val("inst_pc",   bus.inst_pc,   q_pc[0]);
                check_val("inst_data", bus.inst_data, q_data[0]);
            end
            if (prev_rst) begin
                check_val("post_rst_inst_data", bus.inst_data, 0);
                check_val("post_rst_inst_pc",   bus.inst_pc,   0);
            end

            m_issue   = exp_req && bus.mem_gnt;
            dut_issue = bus.mem_req && bus.mem_gnt;
            rv        = bus.mem_rvalid;

            if (rst) begin
                q_pc.delete();
                q_data.delete();
                m_pc  = RESET_PC;
                m_out = 0;
            end else begin
                resp = rv && m_out;
                pop  = exp_valid && bus.inst_ready;
                if (pop) begin
                    void'(q_pc.pop_front());
                    void'(q_data.pop_front());
                end
                if (bus.redirect) begin
                    q_pc.delete();
                    q_data.delete();
                    if (m_issue) begin
                        m_out  = 1;
                        m_keep = 0;
                    end else if (resp) begin
                        m_out = 0;
                    end else begin
                        m_keep = 0;
                    end
                    m_pc = bus.redirect_pc;
                end else begin
                    if (resp) begin
                        if (m_keep) begin
                            q_pc.push_back(m_out_pc);
                            q_data.push_back(mem[m_out_pc]);
                        end
                        m_out = 0;
                    end
                    if (m_issue) begin
                        m_out    = 1;
                        m_keep   = 1;
                        m_out_pc = m_pc;
                        m_pc     = m_pc + 8'd1;
                    end
                end
            end

            if (deliver) begin
                pend_v = 0;
            end else if (pend_v) begin
                if (rst) pend_cnt = 0;
                else     pend_cnt--;
            end
            if (dut_issue) begin
                pend_v    = 1;
                pend_addr = bus.mem_addr;
                pend_cnt  = (phase == 0) ? 0 : $urandom_range(0, 2);
            end
            prev_rst = rst;

            @(posedge clk);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
